csr_unit: RTL and testbench
===========================

Name: csr_unit

Overview:
- Parametrised successor of the core CSR file. Sits in the WB stage; it is written by csrwr/csrxchg and read by csrrd.
- Adds the following over the previous block:
  - BADV register.
  - TID register.
  - Constant timer: TCFG, TVAL and TICLR.
  - Registered hardware interrupt inputs.
  - A configurable number of SAVE registers.
  - A 64-bit stable counter for rdcntv{l,h}.w.
- Drives has_int, exc_entry and exc_retaddr to the pipeline.

Parameters:
- SAVE_NUM, 4: number of SAVE registers (1..16), mapped at 0x30..0x30+SAVE_NUM-1.
- HW_INT_NUM, 8: number of hardware interrupt lines (1..8), mapped to ESTAT.IS[2+HW_INT_NUM-1:2].
- TIMER_W, 32: timer width (8..32). TCFG.InitVal occupies bits [TIMER_W-1:2].
- TID_RESET, 32'h0: reset value of TID.

Ports:
- clk, input, 1: clock.
- resetn, input, 1: synchronous, active-low reset.
- csr_we, input, 1: write enable.
- csr_wnum, input, 14: write CSR number.
- csr_wmask, input, 32: bit write mask.
- csr_wval, input, 32: write data.
- csr_rnum, input, 14: read CSR number.
- csr_rval, output, 32: combinational read data. Unmapped numbers read 0.
- wb_exc, input, 1: exception commits this cycle.
- wb_ecode, input, 6: exception code.
- wb_esubcode, input, 9: exception subcode.
- wb_pc, input, 32: PC of the faulting instruction.
- wb_vaddr, input, 32: bad virtual address.
- ertn_flush, input, 1: ertn commits.
- hw_int_in, input, HW_INT_NUM: level hardware interrupts.
- has_int, output, 1: interrupt pending and enabled.
- exc_entry, output, 32: EENTRY value.
- exc_retaddr, output, 32: ERA value.
- stable_cnt, output, 64: stable counter value.

Behaviour:
- CSR numbers:
  - CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC.
  - SAVEn 0x30+n.
  - TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.
- Masked write rule: new = wmask&wval | ~wmask&old, applied to writable fields only.
- Priority per register: reset > wb_exc > ertn_flush > csr write.
- Reset (resetn==0 at posedge):
  - CRMD.PLV=0, CRMD.IE=0.
  - ECFG.LIE=0, ESTAT.IS=0.
  - TCFG.En=0, TVAL=0, TID=TID_RESET.
  - stable_cnt=0.
  - Resulting outputs: has_int=0, stable_cnt=0.
  - PRMD, ERA, BADV, EENTRY and SAVE are not reset.
- On wb_exc:
  - PRMD takes the old CRMD (PPLV/PIE); CRMD becomes PLV=0, IE=0.
  - ESTAT.Ecode/EsubCode are loaded; ERA=wb_pc.
  - BADV=wb_vaddr only when wb_ecode is ADEF (0x08) or ALE (0x09).
- On ertn_flush: CRMD.PLV/IE are restored from PRMD.
- ESTAT.IS fields:
  - IS[1:0] is software-writable.
  - IS[2+HW_INT_NUM-1:2] is registered from hw_int_in every cycle (1-cycle latency). Unused hardware bits read 0.
  - IS[11] is the timer interrupt, cleared by a TICLR write with wval[0]&wmask[0]=1.
  - IS[10] and IS[12] read 0.
  - If timer expiry and the TICLR clear occur in the same cycle, expiry wins: IS[11]=1.
- TCFG write:
  - The TCFG register is updated.
  - If the new En=1, TVAL is loaded with {InitVal,2'b00} (zero-extended to 32) in the same edge.
- Timer state machine:
  - IDLE: En=0. TVAL holds.
  - RUN: En=1 and TVAL!=0. TVAL decrements by 1 per cycle.
  - EXPIRE: TVAL==1 in RUN. The next edge sets TVAL=0 and IS[11]=1.
  - After expiry in periodic mode (Periodic=1): the cycle after TVAL reaches 0, TVAL is reloaded with {InitVal,2'b00} and RUN continues.
  - After expiry otherwise: stop at 0 with no wrap (DONE).
  - A TCFG write in any state restarts per the TCFG write rule. En=0 freezes TVAL.
  - InitVal=0 with En=1 loads TVAL=0: no count and no interrupt.
- TVAL and TICLR are read-only; writes to them are ignored, except that a TICLR write clears IS[11]. TICLR reads 0.
- TID is fully writable.
- stable_cnt increments by 1 every cycle and wraps at 2^64-1 to 0.
- has_int = |(ESTAT.IS[12:0] & ECFG.LIE[12:0]) & CRMD.IE. It is combinational from registers.
- Read values:
  - TCFG reads {0, InitVal, Periodic, En}.
  - EENTRY reads {VA[31:6], 6'b0}.
- Writes to SAVE indices >= SAVE_NUM are ignored and read 0.

Test Plan:
- Reset, then read all CSRs -> CRMD=0, ECFG=0, ESTAT.IS=0, TID=TID_RESET, stable_cnt=0 and 1 one cycle after release; has_int=0.
- Write TCFG=0x0000_0011 (InitVal=4, En=1, non-periodic) -> TVAL=0x10 next cycle, then counts down 16 cycles to 0. IS[11]=1 on the edge TVAL hits 0, then TVAL stays 0.
- Write TCFG=0x0000_000B (periodic, InitVal=2) -> TVAL 8..0 repeats every 9 cycles. A TICLR write of 1 coincident with expiry leaves IS[11]=1.
- ECFG=0x800, CRMD.IE=1, timer expiry -> has_int=1. Then wb_exc=1, ecode 0, pc 0x1c000100 -> CRMD.IE=0, PRMD.PIE=1, ERA=0x1c000100, has_int=0. Then ertn_flush -> IE=1, has_int=1.
- Exception with ecode 0x09 and vaddr 0x80000003 -> BADV=0x80000003. The same stimulus with ecode 0x0B leaves BADV unchanged.
- hw_int_in[0]=1 with LIE[2]=1, IE=1 -> IS[2]=1 and has_int=1 after exactly 1 cycle. SAVE_NUM=2: writing 0x32 reads back 0.

Source files
------------

// File: rtl/csr_unit_if.sv
// csr_unit_if: pipeline <-> CSR file connection.
// master : WB stage side. Drives write/read requests, exception/ertn commits and
//          hardware interrupt lines. Receives read data, has_int, the exception
//          entry/return addresses and the stable counter.
// slave  : csr_unit side (directions mirrored).
interface csr_unit_if #(
    parameter int unsigned HW_INT_NUM = 8
);
    logic                  csr_we;
    logic [13:0]           csr_wnum;
    logic [31:0]           csr_wmask;
    logic [31:0]           csr_wval;
    logic [13:0]           csr_rnum;
    logic [31:0]           csr_rval;
    logic                  wb_exc;
    logic [5:0]            wb_ecode;
    logic [8:0]            wb_esubcode;
    logic [31:0]           wb_pc;
    logic [31:0]           wb_vaddr;
    logic                  ertn_flush;
    logic [HW_INT_NUM-1:0] hw_int_in;
    logic                  has_int;
    logic [31:0]           exc_entry;
    logic [31:0]           exc_retaddr;
    logic [63:0]           stable_cnt;

    modport master (
        output csr_we, csr_wnum, csr_wmask, csr_wval, csr_rnum,
        output wb_exc, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush, hw_int_in,
        input  csr_rval, has_int, exc_entry, exc_retaddr, stable_cnt
    );

    modport slave (
        input  csr_we, csr_wnum, csr_wmask, csr_wval, csr_rnum,
        input  wb_exc, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush, hw_int_in,
        output csr_rval, has_int, exc_entry, exc_retaddr, stable_cnt
    );
endinterface

// File: rtl/csr_unit.sv
// csr_unit: WB-stage control/status register file with constant timer, registered
// hardware interrupts, SAVE scratch registers and a 64-bit stable counter.
// Ports:
//   clk     - clock
//   resetn  - synchronous active-low reset
//   csr_bus - csr_unit_if.slave: CSR read/write, exception/ertn commit, hw_int_in,
//             has_int, exc_entry (EENTRY), exc_retaddr (ERA), stable_cnt
module csr_unit #(
    parameter int unsigned SAVE_NUM   = 4,
    parameter int unsigned HW_INT_NUM = 8,
    parameter int unsigned TIMER_W    = 32,
    parameter logic [31:0] TID_RESET  = 32'h0
) (
    input  logic      clk,
    input  logic      resetn,
    csr_unit_if.slave csr_bus
);
    localparam logic [13:0] CsrCrmd   = 14'h000;
    localparam logic [13:0] CsrPrmd   = 14'h001;
    localparam logic [13:0] CsrEcfg   = 14'h004;
    localparam logic [13:0] CsrEstat  = 14'h005;
    localparam logic [13:0] CsrEra    = 14'h006;
    localparam logic [13:0] CsrBadv   = 14'h007;
    localparam logic [13:0] CsrEentry = 14'h00C;
    localparam logic [13:0] CsrTid    = 14'h040;
    localparam logic [13:0] CsrTcfg   = 14'h041;
    localparam logic [13:0] CsrTval   = 14'h042;
    localparam logic [13:0] CsrTiclr  = 14'h044;

    typedef enum logic [1:0] {TmIdle, TmRun, TmReload, TmDone} tmr_state_e;

    logic [1:0]            r_crmd_plv;
    logic                  r_crmd_ie;
    logic [1:0]            r_prmd_pplv;
    logic                  r_prmd_pie;
    logic [12:0]           r_ecfg_lie;
    logic [1:0]            r_is_sw;
    logic [HW_INT_NUM-1:0] r_is_hw;
    logic                  r_is_timer;
    logic [5:0]            r_ecode;
    logic [8:0]            r_esubcode;
    logic [31:0]           r_era;
    logic [31:0]           r_badv;
    logic [25:0]           r_eentry_va;
    logic [31:0]           r_save [SAVE_NUM];
    logic [31:0]           r_tid;
    logic                  r_tcfg_en;
    logic                  r_tcfg_per;
    logic [TIMER_W-3:0]    r_tcfg_init;
    logic [TIMER_W-1:0]    r_tval;
    tmr_state_e            r_tstate;
    logic [63:0]           r_stable_cnt;

    logic [12:0]        w_estat_is;
    logic [31:0]        w_tcfg_rd;
    logic [31:0]        w_tval_rd;
    logic [31:0]        w_rdata;
    logic [31:0]        w_wold;
    logic [31:0]        w_wnew;
    logic               w_we;
    logic               w_we_crmd, w_we_prmd, w_we_ecfg, w_we_estat, w_we_era;
    logic               w_we_badv, w_we_eentry, w_we_tid, w_we_tcfg, w_we_save;
    logic               w_ticlr_clr;
    logic               w_timer_fire;
    logic [TIMER_W-1:0] w_tval_d;
    tmr_state_e         w_tstate_d;

    always_comb begin
        w_estat_is = '0;
        w_estat_is[1:0] = r_is_sw;
        w_estat_is[2 +: HW_INT_NUM] = r_is_hw;
        w_estat_is[11] = r_is_timer;
        w_tcfg_rd = '0;
        w_tcfg_rd[TIMER_W-1:0] = {r_tcfg_init, r_tcfg_per, r_tcfg_en};
        w_tval_rd = '0;
        w_tval_rd[TIMER_W-1:0] = r_tval;
    end

    function automatic logic [31:0] csr_read(input logic [13:0] num);
        logic [31:0] v;
        v = '0;
        case (num)
            CsrCrmd:   v = {29'b0, r_crmd_ie, r_crmd_plv};
            CsrPrmd:   v = {29'b0, r_prmd_pie, r_prmd_pplv};
            CsrEcfg:   v = {19'b0, r_ecfg_lie};
            CsrEstat:  v = {1'b0, r_esubcode, r_ecode, 3'b0, w_estat_is};
            CsrEra:    v = r_era;
            CsrBadv:   v = r_badv;
            CsrEentry: v = {r_eentry_va, 6'b0};
            CsrTid:    v = r_tid;
            CsrTcfg:   v = w_tcfg_rd;
            CsrTval:   v = w_tval_rd;
            default:   v = '0;
        endcase
        if (num[13:4] == 10'h003) begin
            for (int unsigned i = 0; i < SAVE_NUM; i++) begin
                if (num[3:0] == 4'(i)) v = r_save[i];
            end
        end
        return v;
    endfunction

    // The write side reuses the read mux so masked writes merge with the visible value.
    always_comb begin
        w_rdata = csr_read(csr_bus.csr_rnum);
        w_wold  = csr_read(csr_bus.csr_wnum);
        w_wnew  = (csr_bus.csr_wmask & csr_bus.csr_wval) | (~csr_bus.csr_wmask & w_wold);
    end

    // A faulting instruction never retires its own CSR write.
    assign w_we        = csr_bus.csr_we & ~csr_bus.wb_exc;
    assign w_we_crmd   = w_we && (csr_bus.csr_wnum == CsrCrmd);
    assign w_we_prmd   = w_we && (csr_bus.csr_wnum == CsrPrmd);
    assign w_we_ecfg   = w_we && (csr_bus.csr_wnum == CsrEcfg);
    assign w_we_estat  = w_we && (csr_bus.csr_wnum == CsrEstat);
    assign w_we_era    = w_we && (csr_bus.csr_wnum == CsrEra);
    assign w_we_badv   = w_we && (csr_bus.csr_wnum == CsrBadv);
    assign w_we_eentry = w_we && (csr_bus.csr_wnum == CsrEentry);
    assign w_we_tid    = w_we && (csr_bus.csr_wnum == CsrTid);
    assign w_we_tcfg   = w_we && (csr_bus.csr_wnum == CsrTcfg);
    assign w_we_save   = w_we && (csr_bus.csr_wnum[13:4] == 10'h003);
    assign w_ticlr_clr = w_we && (csr_bus.csr_wnum == CsrTiclr)
                         && csr_bus.csr_wmask[0] && csr_bus.csr_wval[0];

    // Timer next state. Expiry (TVAL 1 -> 0) happens inside TmRun; TmReload is the
    // single cycle periodic mode spends at 0 before reloading.
    always_comb begin
        w_tstate_d   = r_tstate;
        w_tval_d     = r_tval;
        w_timer_fire = 1'b0;
        if (w_we_tcfg) begin
            if (w_wnew[0]) begin
                w_tval_d   = {w_wnew[TIMER_W-1:2], 2'b00};
                w_tstate_d = (w_wnew[TIMER_W-1:2] != '0) ? TmRun : TmIdle;
            end else begin
                w_tstate_d = TmIdle;
            end
        end else begin
            case (r_tstate)
                TmRun: begin
                    w_tval_d = r_tval - TIMER_W'(1);
                    if (r_tval == TIMER_W'(1)) begin
                        w_timer_fire = 1'b1;
                        w_tstate_d   = r_tcfg_per ? TmReload : TmDone;
                    end
                end
                TmReload: begin
                    w_tval_d   = {r_tcfg_init, 2'b00};
                    w_tstate_d = (r_tcfg_init != '0) ? TmRun : TmIdle;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_crmd_plv   <= '0;
            r_crmd_ie    <= 1'b0;
            r_ecfg_lie   <= '0;
            r_is_sw      <= '0;
            r_is_hw      <= '0;
            r_is_timer   <= 1'b0;
            r_tcfg_en    <= 1'b0;
            r_tcfg_per   <= 1'b0;
            r_tcfg_init  <= '0;
            r_tval       <= '0;
            r_tstate     <= TmIdle;
            r_tid        <= TID_RESET;
            r_stable_cnt <= '0;
        end else begin
            if (csr_bus.wb_exc) begin
                r_crmd_plv <= 2'b00;
                r_crmd_ie  <= 1'b0;
            end else if (csr_bus.ertn_flush) begin
                r_crmd_plv <= r_prmd_pplv;
                r_crmd_ie  <= r_prmd_pie;
            end else if (w_we_crmd) begin
                r_crmd_plv <= w_wnew[1:0];
                r_crmd_ie  <= w_wnew[2];
            end
            // LIE[10] has no source behind it and stays 0.
            if (w_we_ecfg) r_ecfg_lie <= w_wnew[12:0] & 13'h1bff;
            if (w_we_estat) r_is_sw <= w_wnew[1:0];
            r_is_hw <= csr_bus.hw_int_in;
            // Expiry wins over a coincident TICLR clear.
            if (w_timer_fire) begin
                r_is_timer <= 1'b1;
            end else if (w_ticlr_clr) begin
                r_is_timer <= 1'b0;
            end
            if (w_we_tcfg) begin
                r_tcfg_en   <= w_wnew[0];
                r_tcfg_per  <= w_wnew[1];
                r_tcfg_init <= w_wnew[TIMER_W-1:2];
            end
            r_tval   <= w_tval_d;
            r_tstate <= w_tstate_d;
            if (w_we_tid) r_tid <= w_wnew;
            r_stable_cnt <= r_stable_cnt + 64'd1;
        end
    end

    // Registers without reset.
    always_ff @(posedge clk) begin
        if (csr_bus.wb_exc) begin
            r_prmd_pplv <= r_crmd_plv;
            r_prmd_pie  <= r_crmd_ie;
            r_ecode     <= csr_bus.wb_ecode;
            r_esubcode  <= csr_bus.wb_esubcode;
            r_era       <= csr_bus.wb_pc;
            // Only ADEF and ALE report a bad address.
            if (csr_bus.wb_ecode == 6'h08 || csr_bus.wb_ecode == 6'h09) begin
                r_badv <= csr_bus.wb_vaddr;
            end
        end else begin
            if (w_we_prmd) begin
                r_prmd_pplv <= w_wnew[1:0];
                r_prmd_pie  <= w_wnew[2];
            end
            if (w_we_era)  r_era  <= w_wnew;
            if (w_we_badv) r_badv <= w_wnew;
        end
        if (w_we_eentry) r_eentry_va <= w_wnew[31:6];
        for (int unsigned i = 0; i < SAVE_NUM; i++) begin
            if (w_we_save && csr_bus.csr_wnum[3:0] == 4'(i)) r_save[i] <= w_wnew;
        end
    end

    assign csr_bus.csr_rval    = w_rdata;
    assign csr_bus.has_int     = |(w_estat_is & r_ecfg_lie) & r_crmd_ie;
    assign csr_bus.exc_entry   = {r_eentry_va, 6'b0};
    assign csr_bus.exc_retaddr = r_era;
    assign csr_bus.stable_cnt  = r_stable_cnt;
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed self-checking bench for csr_unit (SAVE_NUM=2, 8 hw lines,
// 32-bit timer). Inputs change on the falling edge; outputs are read there or
// shortly after, away from the rising edge.
module tb_csr_unit;
    localparam logic [31:0] TidReset = 32'h0BAD_F00D;
    localparam logic [13:0] Crmd   = 14'h000;
    localparam logic [13:0] Prmd   = 14'h001;
    localparam logic [13:0] Ecfg   = 14'h004;
    localparam logic [13:0] Estat  = 14'h005;
    localparam logic [13:0] Era    = 14'h006;
    localparam logic [13:0] Badv   = 14'h007;
    localparam logic [13:0] Eentry = 14'h00C;
    localparam logic [13:0] Save0  = 14'h030;
    localparam logic [13:0] Save1  = 14'h031;
    localparam logic [13:0] Save2  = 14'h032;
    localparam logic [13:0] Tid    = 14'h040;
    localparam logic [13:0] Tcfg   = 14'h041;
    localparam logic [13:0] Tval   = 14'h042;
    localparam logic [13:0] Ticlr  = 14'h044;

    logic        clk = 1'b0;
    logic        resetn;
    logic [63:0] exp_cnt = '0;
    int          n_vec;
    int          n_miss;

    always #5 clk = ~clk;

    csr_unit_if #(.HW_INT_NUM(8)) bus ();

    csr_unit #(
        .SAVE_NUM  (2),
        .HW_INT_NUM(8),
        .TIMER_W   (32),
        .TID_RESET (TidReset)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .csr_bus(bus)
    );

    // Reference for the stable counter: zero under reset, +1 per rising edge otherwise.
    always @(posedge clk) exp_cnt <= resetn ? exp_cnt + 64'd1 : 64'd0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [13:0] num, input logic [31:0] mask,
                          input logic [31:0] exp);
        bus.csr_rnum = num;
        #1;
        check_eq(tag, 64'(bus.csr_rval & mask), 64'(exp));
    endtask

    task automatic csr_wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
        bus.csr_we    = 1'b1;
        bus.csr_wnum  = num;
        bus.csr_wmask = mask;
        bus.csr_wval  = val;
        @(negedge clk);
        bus.csr_we = 1'b0;
    endtask

    task automatic exc_pulse(input logic [5:0] ecode, input logic [8:0] esub,
                             input logic [31:0] pc, input logic [31:0] vaddr);
        bus.wb_exc      = 1'b1;
        bus.wb_ecode    = ecode;
        bus.wb_esubcode = esub;
        bus.wb_pc       = pc;
        bus.wb_vaddr    = vaddr;
        @(negedge clk);
        bus.wb_exc = 1'b0;
    endtask

    task automatic ertn_pulse();
        bus.ertn_flush = 1'b1;
        @(negedge clk);
        bus.ertn_flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        n_vec  = 0;
        n_miss = 0;
        resetn          = 1'b0;
        bus.csr_we      = 1'b0;
        bus.csr_wnum    = '0;
        bus.csr_wmask   = '0;
        bus.csr_wval    = '0;
        bus.csr_rnum    = '0;
        bus.wb_exc      = 1'b0;
        bus.wb_ecode    = '0;
        bus.wb_esubcode = '0;
        bus.wb_pc       = '0;
        bus.wb_vaddr    = '0;
        bus.ertn_flush  = 1'b0;
        bus.hw_int_in   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_has_int", 64'(bus.has_int), 64'd0);
        check_eq("rst_cnt", bus.stable_cnt, 64'd0);
        rd_chk("rst_crmd", Crmd, '1, 32'h0);
        rd_chk("rst_ecfg", Ecfg, '1, 32'h0);
        rd_chk("rst_estat_is", Estat, 32'h1fff, 32'h0);
        rd_chk("rst_tid", Tid, '1, TidReset);
        @(negedge clk);
        rd_chk("rst_tcfg", Tcfg, '1, 32'h0);
        rd_chk("rst_tval", Tval, '1, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_eq("cnt_after_release", bus.stable_cnt, 64'd1);

        // One-shot timer: InitVal=4 -> 16 cycles down to 0, then stays
        csr_wr(Tcfg, '1, 32'h11);
        rd_chk("os_tval_load", Tval, '1, 32'h10);
        rd_chk("os_tcfg_rd", Tcfg, '1, 32'h11);
        for (int k = 15; k >= 0; k--) begin
            @(negedge clk);
            rd_chk("os_tval", Tval, '1, 32'(k));
            rd_chk("os_is11", Estat, 32'h800, (k == 0) ? 32'h800 : 32'h0);
        end
        repeat (2) @(negedge clk);
        rd_chk("os_hold_zero", Tval, '1, 32'h0);
        @(negedge clk);
        csr_wr(Ticlr, 32'h1, 32'h1);
        rd_chk("ticlr_clear", Estat, 32'h800, 32'h0);
        rd_chk("ticlr_reads0", Ticlr, '1, 32'h0);

        // Periodic timer: InitVal=2 -> 8..0 every 9 cycles; clear vs expiry
        @(negedge clk);
        csr_wr(Tcfg, '1, 32'h0B);
        for (int k = 0; k < 18; k++) begin
            if (k > 0) @(negedge clk);
            bus.csr_we = 1'b0;
            rd_chk("per_tval", Tval, '1, 32'(8 - (k % 9)));
            if (k == 7 || k == 11) rd_chk("per_is11_low", Estat, 32'h800, 32'h0);
            if (k == 8 || k == 17) rd_chk("per_is11_high", Estat, 32'h800, 32'h800);
            if (k == 10 || k == 16) begin
                bus.csr_we    = 1'b1;
                bus.csr_wnum  = Ticlr;
                bus.csr_wmask = 32'h1;
                bus.csr_wval  = 32'h1;
            end
        end
        bus.csr_we = 1'b0;

        // En=0 freezes TVAL
        @(negedge clk);
        csr_wr(Tcfg, '1, 32'h11);
        @(negedge clk);
        csr_wr(Tcfg, '1, 32'h10);
        repeat (3) @(negedge clk);
        rd_chk("freeze_tval", Tval, '1, 32'd15);
        rd_chk("tval_ro_pre", Tcfg, '1, 32'h10);
        @(negedge clk);
        csr_wr(Tval, '1, 32'hffff_ffff);
        rd_chk("tval_ro", Tval, '1, 32'd15);

        // Timer interrupt, exception entry and ertn
        @(negedge clk);
        csr_wr(Ticlr, 32'h1, 32'h1);
        csr_wr(Ecfg, '1, 32'h800);
        csr_wr(Crmd, '1, 32'h7);
        rd_chk("crmd_rw", Crmd, '1, 32'h7);
        rd_chk("ecfg_rw", Ecfg, '1, 32'h800);
        check_eq("int_idle", 64'(bus.has_int), 64'd0);
        @(negedge clk);
        csr_wr(Tcfg, '1, 32'h5);
        for (int k = 3; k >= 0; k--) begin
            @(negedge clk);
            check_eq("int_timer", 64'(bus.has_int), (k == 0) ? 64'd1 : 64'd0);
        end
        exc_pulse(6'h00, 9'h000, 32'h1c00_0100, 32'h0);
        rd_chk("exc_crmd", Crmd, '1, 32'h0);
        rd_chk("exc_prmd", Prmd, '1, 32'h7);
        rd_chk("exc_era", Era, '1, 32'h1c00_0100);
        check_eq("exc_has_int", 64'(bus.has_int), 64'd0);
        check_eq("exc_retaddr", 64'(bus.exc_retaddr), 64'h1c00_0100);
        @(negedge clk);
        ertn_pulse();
        rd_chk("ertn_crmd", Crmd, '1, 32'h7);
        check_eq("ertn_has_int", 64'(bus.has_int), 64'd1);

        // BADV only for ADEF/ALE
        @(negedge clk);
        exc_pulse(6'h09, 9'h001, 32'h1c00_0200, 32'h8000_0003);
        rd_chk("badv_ale", Badv, '1, 32'h8000_0003);
        rd_chk("estat_code", Estat, 32'h7fff_0000, 32'h0049_0000);
        @(negedge clk);
        exc_pulse(6'h0B, 9'h000, 32'h1c00_0300, 32'h1234_5678);
        rd_chk("badv_keep", Badv, '1, 32'h8000_0003);
        rd_chk("era_update", Era, '1, 32'h1c00_0300);

        // Software IS bits; Ecode is not CSR-writable
        @(negedge clk);
        csr_wr(Estat, '1, 32'h7fff_ffff);
        rd_chk("estat_sw_is", Estat, 32'h3, 32'h3);
        rd_chk("estat_code_ro", Estat, 32'h7fff_0000, 32'h000b_0000);
        @(negedge clk);
        csr_wr(Estat, 32'h3, 32'h0);

        // Hardware interrupt, one cycle latency
        csr_wr(Ticlr, 32'h1, 32'h1);
        csr_wr(Ecfg, '1, 32'h4);
        csr_wr(Crmd, '1, 32'h4);
        bus.hw_int_in = 8'h01;
        #1;
        check_eq("hw_before_edge", 64'(bus.has_int), 64'd0);
        @(negedge clk);
        rd_chk("hw_is2", Estat, 32'h1fff, 32'h004);
        check_eq("hw_has_int", 64'(bus.has_int), 64'd1);
        bus.hw_int_in = 8'h80;
        @(negedge clk);
        rd_chk("hw_is9", Estat, 32'h1fff, 32'h200);
        check_eq("hw_lie_masked", 64'(bus.has_int), 64'd0);
        bus.hw_int_in = 8'h00;

        // SAVE, TID, EENTRY, unmapped numbers
        @(negedge clk);
        csr_wr(Save0, '1, 32'hdead_beef);
        csr_wr(Save1, '1, 32'hcafe_f00d);
        csr_wr(Save2, '1, 32'h5555_5555);
        csr_wr(Save0, 32'h0000_ffff, 32'h1234_5678);
        rd_chk("save0_masked", Save0, '1, 32'hdead_5678);
        rd_chk("save1", Save1, '1, 32'hcafe_f00d);
        rd_chk("save2_absent", Save2, '1, 32'h0);
        rd_chk("unmapped", 14'h003, '1, 32'h0);
        @(negedge clk);
        csr_wr(Tid, '1, 32'h8765_4321);
        csr_wr(Eentry, '1, 32'hffff_ffff);
        rd_chk("tid_rw", Tid, '1, 32'h8765_4321);
        rd_chk("eentry_rd", Eentry, '1, 32'hffff_ffc0);
        check_eq("exc_entry", 64'(bus.exc_entry), 64'hffff_ffc0);
        @(negedge clk);
        check_eq("stable_cnt", bus.stable_cnt, exp_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
